// File: rtl/axis_packet_master_if.sv
// axis_packet_master_if: user write side plus AXI4-Stream master bundle for axis_packet_master
interface axis_packet_master_if #(parameter int DEPTH = 16, parameter int LEN_W = 5);
  logic wr_en;
  logic [7:0] wr_data;
  logic [LEN_W-1:0] pkt_len;
  logic full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic busy;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tready;
  modport master(
    input wr_en, wr_data, pkt_len, m_axis_tready,
    output full, fifo_count, busy, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
  modport slave(
    output wr_en, wr_data, pkt_len, m_axis_tready,
    input full, fifo_count, busy, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_packet_master.sv
// axis_packet_master: byte FIFO that emits fixed-length AXI4-Stream packets once a whole packet is stored
// Ports: m_axis_aclk clock, m_axis_arst async active-high reset, bus (master modport) with the user
// write side (wr_en, wr_data, pkt_len, full, fifo_count, busy) and the AXIS master (tdata/tvalid/tlast/tready).
// Macro AXIS_PKT_STATS_EN adds pkt_sent (completed packets, wrapping) and stall_seen (sticky tready-low flag).
module axis_packet_master #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 5
) (
  input logic m_axis_aclk,
  input logic m_axis_arst,
  axis_packet_master_if.master bus
`ifdef AXIS_PKT_STATS_EN
  ,
  output logic [15:0] pkt_sent,
  output logic stall_seen
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = CW > LEN_W ? CW : LEN_W;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [LEN_W-1:0] beat_q, beat_d, len_q, len_d, len_eff;
  logic wr_acc, fire, last, stream;
  always_comb begin
    stream = state_q == STREAM;
    len_eff = bus.pkt_len == '0 ? LEN_W'(1) : bus.pkt_len;
    wr_acc = bus.wr_en && count_q != CW'(DEPTH);
    last = stream && beat_q == len_q - LEN_W'(1);
    fire = stream && bus.m_axis_tready;
    wr_ptr_d = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d = rd_ptr_q + AW'(fire);
    count_d = count_q + CW'(wr_acc) - CW'(fire);
    state_d = state_q;
    beat_d = beat_q;
    len_d = len_q;
    if (!stream && MW'(count_q) >= MW'(len_eff)) begin
      state_d = STREAM;
      beat_d = '0;
      len_d = len_eff;
    end else if (fire) begin
      beat_d = beat_q + LEN_W'(1);
      state_d = last ? IDLE : STREAM;
    end
  end
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      beat_q <= '0;
      len_q <= LEN_W'(1);
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      beat_q <= beat_d;
      len_q <= len_d;
    end
  end
  // storage is never reset; the pointer reset makes old contents unreachable
  always_ff @(posedge m_axis_aclk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end
  assign bus.full = count_q == CW'(DEPTH);
  assign bus.fifo_count = count_q;
  assign bus.busy = stream;
  assign bus.m_axis_tvalid = stream;
  assign bus.m_axis_tdata = stream ? mem_q[rd_ptr_q] : 8'h00;
  assign bus.m_axis_tlast = last;
`ifdef AXIS_PKT_STATS_EN
  logic [15:0] pkt_sent_q, pkt_sent_d;
  logic stall_q, stall_d;
  always_comb begin
    pkt_sent_d = pkt_sent_q + 16'(fire && last);
    stall_d = stall_q | (stream && !bus.m_axis_tready);
  end
  always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
    if (m_axis_arst) begin
      pkt_sent_q <= '0;
      stall_q <= 1'b0;
    end else begin
      pkt_sent_q <= pkt_sent_d;
      stall_q <= stall_d;
    end
  end
  assign pkt_sent = pkt_sent_q;
  assign stall_seen = stall_q;
`endif
endmodule

// File: tb/tb_axis_packet_master.sv
// tb_axis_packet_master: table vectors, directed corner sequences and random traffic against a queue model
module tb_axis_packet_master;
  localparam int DEPTH = 16;
  localparam int LEN_W = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  axis_packet_master_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();
`ifdef AXIS_PKT_STATS_EN
  logic [15:0] pkt_sent;
  logic stall_seen;
`endif
  axis_packet_master #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .m_axis_aclk(clk),
    .m_axis_arst(rst),
    .bus(bus.master)
`ifdef AXIS_PKT_STATS_EN
    ,
    .pkt_sent(pkt_sent),
    .stall_seen(stall_seen)
`endif
  );
  typedef struct {
    logic we;
    logic [7:0] wd;
    logic [LEN_W-1:0] pl;
    logic rdy;
    logic ev;
    logic [7:0] ed;
    logic el;
    logic eb;
    logic [4:0] ec;
  } vec_t;
  int nvec = 0;
  int nerr = 0;
  logic [7:0] q[$];
  bit act;
  int left;
  int sent;
  bit stall;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [16:0] dut_out();
    return {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.busy, bus.full, bus.fifo_count};
  endfunction
  function automatic logic [16:0] model_out();
    logic [7:0] d;
    d = act ? q[0] : 8'h00;
    return {act, d, act && left == 1, act, q.size() == DEPTH, 5'(q.size())};
  endfunction
  task automatic model_reset();
    q.delete();
    act = 0;
    left = 0;
    sent = 0;
    stall = 0;
  endtask
  task automatic model_check();
    chk("model", 32'(dut_out()), 32'(model_out()));
`ifdef AXIS_PKT_STATS_EN
    chk("pkt_sent", 32'(pkt_sent), 32'(sent & 16'hffff));
    chk("stall_seen", 32'(stall_seen), 32'(stall));
`endif
  endtask
  task automatic apply(input logic we, input logic [7:0] wd, input logic [LEN_W-1:0] pl, input logic rdy);
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.pkt_len = pl;
    bus.m_axis_tready = rdy;
    #1;
    model_check();
  endtask
  // model step: one packet beat leaves per accepted transfer; a new packet needs a stored full packet
  task automatic advance();
    int n;
    int leff;
    n = q.size();
    leff = bus.pkt_len == 0 ? 1 : int'(bus.pkt_len);
    @(posedge clk);
    if (act && !bus.m_axis_tready) stall = 1;
    if (act && bus.m_axis_tready) begin
      void'(q.pop_front());
      left--;
      if (left == 0) begin
        act = 0;
        sent++;
      end
    end else if (!act && n >= leff) begin
      act = 1;
      left = leff;
    end
    if (bus.wr_en && n < DEPTH) q.push_back(bus.wr_data);
    #1;
  endtask
  task automatic step(input logic we, input logic [7:0] wd, input logic [LEN_W-1:0] pl, input logic rdy);
    apply(we, wd, pl, rdy);
    advance();
  endtask
  task automatic do_reset();
    bus.wr_en = 0;
    bus.wr_data = 0;
    bus.m_axis_tready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  vec_t tbl[10];
  logic [7:0] hold_d;
  logic hold_l;
  logic [6:0] vpat;
  bit got;
  initial begin
    bus.pkt_len = 5'd4;
    model_reset();
    do_reset();
    chk("reset_outputs", 32'(dut_out()), 32'h0);
    tbl[0] = '{1, 8'h11, 4, 1, 0, 8'h00, 0, 0, 0};
    tbl[1] = '{1, 8'h22, 4, 1, 0, 8'h00, 0, 0, 1};
    tbl[2] = '{1, 8'h33, 4, 1, 0, 8'h00, 0, 0, 2};
    tbl[3] = '{1, 8'h44, 4, 1, 0, 8'h00, 0, 0, 3};
    tbl[4] = '{0, 8'h00, 4, 1, 0, 8'h00, 0, 0, 4};
    tbl[5] = '{0, 8'h00, 4, 1, 1, 8'h11, 0, 1, 4};
    tbl[6] = '{0, 8'h00, 4, 1, 1, 8'h22, 0, 1, 3};
    tbl[7] = '{0, 8'h00, 4, 1, 1, 8'h33, 0, 1, 2};
    tbl[8] = '{0, 8'h00, 4, 1, 1, 8'h44, 1, 1, 1};
    tbl[9] = '{0, 8'h00, 4, 1, 0, 8'h00, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].we, tbl[i].wd, tbl[i].pl, tbl[i].rdy);
      chk($sformatf("table%0d", i),
          32'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.busy, bus.fifo_count}),
          32'({tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eb, tbl[i].ec}));
      advance();
    end
    // partial packet never starts
    for (int i = 0; i < 3; i++) step(1, 8'h50 + 8'(i), 4, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 4, 1);
    chk("partial_no_tvalid", 32'(bus.m_axis_tvalid), 0);
    step(1, 8'h53, 4, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 4, 1);
    // stall mid-packet, then back-to-back packets
    for (int i = 0; i < 6; i++) step(1, 8'h60 + 8'(i), 3, 0);
    step(0, 0, 3, 1);
    hold_d = bus.m_axis_tdata;
    hold_l = bus.m_axis_tlast;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 3, 0);
      chk("stall_hold", 32'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast}), 32'({1'b1, hold_d, hold_l}));
    end
    for (int i = 0; i < 7; i++) begin
      vpat[6-i] = bus.m_axis_tvalid;
      step(0, 0, 3, 1);
    end
    chk("one_idle_gap", 32'(vpat), 32'(7'b1101110));
    // fill to full, drop the 17th byte, then wrap pointers
    for (int i = 0; i < 17; i++) step(1, 8'h80 + 8'(i), 16, 0);
    chk("full_flag", 32'({bus.full, bus.fifo_count}), 32'({1'b1, 5'd16}));
    for (int i = 0; i < 18; i++) step(0, 0, 16, 1);
    for (int i = 0; i < 16; i++) step(1, 8'hc0 + 8'(i), 16, 0);
    chk("refill_full", 32'(bus.full), 1);
    for (int i = 0; i < 18; i++) step(0, 0, 16, 1);
    // async reset during beat 2
    for (int i = 0; i < 4; i++) step(1, 8'h90 + 8'(i), 4, 0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.m_axis_tvalid) got = 1;
      else step(0, 0, 4, 0);
    end
    chk("tvalid_timeout", 32'(got), 1);
    step(0, 0, 4, 1);
    #2 rst = 1;
    #1;
    chk("async_reset", 32'({bus.m_axis_tvalid, bus.busy, bus.fifo_count}), 0);
    model_reset();
    bus.wr_en = 0;
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 4, 1);
    // pkt_len 0 acts as 1
    do_reset();
    step(1, 8'ha5, 0, 1);
    step(0, 0, 0, 1);
    chk("len0_beat", 32'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast}), 32'({1'b1, 8'ha5, 1'b1}));
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
`ifdef AXIS_PKT_STATS_EN
    chk("len0_sent", 32'(pkt_sent), 1);
`endif
    // random traffic
    do_reset();
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 5'($urandom_range(0, 9)), 1'($urandom_range(0, 3) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
